// File: rtl/sentinel_pkg.sv
// Shared types and defaults for the Sentinel key front-end.
// Key width, throttle states and parameter defaults.
package sentinel_pkg;
  localparam int KEY_W = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int MAX_ATTEMPTS_DEF = 3;
  localparam int BACKOFF_CYCLES_DEF = 1024;

  typedef enum logic {
    OPEN,
    BACKOFF
  } throttle_e;
endpackage

// File: rtl/sentinel_sync2.sv
// Two-flop synchroniser for an asynchronous bus.
// Both stages reset to zero; nothing sits between them.
module sentinel_sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/sentinel_key_conditioner.sv
// Debounces the DIP key and rate-limits accepted key changes.
// Too many attempts blank the key port for a backoff window.
module sentinel_key_conditioner #(
  parameter int KEY_W = sentinel_pkg::KEY_W,
  parameter int DEBOUNCE_CYCLES = sentinel_pkg::DEBOUNCE_CYCLES_DEF,
  parameter int MAX_ATTEMPTS = sentinel_pkg::MAX_ATTEMPTS_DEF,
  parameter int BACKOFF_CYCLES = sentinel_pkg::BACKOFF_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [KEY_W-1:0] raw_key,
  input  logic             clear_attempts,
  output logic [KEY_W-1:0] key_out,
  output logic             key_stable,
  output logic             key_strobe,
  output logic             throttled,
  output logic [3:0]       attempt_cnt
);
  import sentinel_pkg::*;

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(BACKOFF_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] T_LOAD = TW'(BACKOFF_CYCLES - 1);
  localparam logic [3:0] ATT_MAX = 4'(MAX_ATTEMPTS);

  logic [KEY_W-1:0] sync_key;
  logic [KEY_W-1:0] candidate;
  logic [CW-1:0]    count;
  logic [TW-1:0]    timer;
  throttle_e        state;

  logic settled;
  logic commit;
  logic bump;
  logic trip;

  sentinel_sync2 #(.W(KEY_W)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (raw_key),
    .q     (sync_key)
  );

  assign settled = (count == CNT_MAX);
  assign commit  = (state == OPEN) & ena & settled
                 & (candidate != key_out);
  assign bump    = commit & (|candidate) & (attempt_cnt != 4'hF);
  // Only an increment that survives a same-edge clear can trip backoff.
  assign trip    = bump & ~clear_attempts
                 & ((attempt_cnt + 4'd1) == ATT_MAX);

  assign key_stable = (state == OPEN) & ena & settled
                    & (candidate == key_out);
  assign throttled  = (state == BACKOFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      candidate   <= '0;
      count       <= '0;
      key_out     <= '0;
      key_strobe  <= 1'b0;
      attempt_cnt <= '0;
      timer       <= '0;
      state       <= OPEN;
    end else begin
      if (sync_key != candidate) begin
        candidate <= sync_key;
        count     <= '0;
      end else if (count != CNT_MAX) begin
        count <= count + 1'b1;
      end

      key_strobe <= 1'b0;

      unique case (state)
        OPEN: begin
          if (!ena) begin
            key_out <= '0;
          end else if (commit) begin
            key_out    <= candidate;
            key_strobe <= 1'b1;
          end
          if (clear_attempts) begin
            attempt_cnt <= '0;
          end else if (bump) begin
            attempt_cnt <= attempt_cnt + 4'd1;
          end
          if (trip) begin
            state <= BACKOFF;
            timer <= T_LOAD;
          end
        end
        BACKOFF: begin
          key_out <= '0;
          if (timer == '0) begin
            state       <= OPEN;
            attempt_cnt <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= OPEN;
      endcase
    end
  end
endmodule

// File: tb/tb_sentinel_key_conditioner.sv
// Scoreboard bench for the key conditioner.
// Expected commits are queued at drive time and matched on strobe.
module tb_sentinel_key_conditioner;
  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] raw_key;
  logic       clear_attempts;
  logic [7:0] key_out;
  logic       key_stable;
  logic       key_strobe;
  logic       throttled;
  logic [3:0] attempt_cnt;

  typedef struct {
    logic [7:0] key;
    logic [3:0] att;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   failures;
  int   bo_bad;
  int   t_bo;

  sentinel_key_conditioner dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena            (ena),
    .raw_key        (raw_key),
    .clear_attempts (clear_attempts),
    .key_out        (key_out),
    .key_stable     (key_stable),
    .key_strobe     (key_strobe),
    .throttled      (throttled),
    .attempt_cnt    (attempt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && key_strobe) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {24'd0, key_out}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_key", {24'd0, key_out}, {24'd0, e.key});
        check("strobe_att", {28'd0, attempt_cnt}, {28'd0, e.att});
        check("strobe_cyc", cyc, e.cyc);
      end
    end
  end

  task automatic set_key(input logic [7:0] v,
                         input logic [3:0] att,
                         input bit push);
    @(negedge clk);
    raw_key = v;
    if (push) sb.push_back('{v, att, cyc + 7});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic bo_tick();
    @(negedge clk);
    if (key_out != 8'h00 || key_stable) bo_bad++;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    bo_bad = 0;
    rst_n = 1'b0;
    ena = 1'b1;
    raw_key = 8'h00;
    clear_attempts = 1'b0;

    #22;
    check("rst_key", {24'd0, key_out}, 0);
    check("rst_stable", {31'd0, key_stable}, 0);
    check("rst_strobe", {31'd0, key_strobe}, 0);
    check("rst_thr", {31'd0, throttled}, 0);
    check("rst_att", {28'd0, attempt_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // first settled key
    set_key(8'hB6, 4'd1, 1'b1);
    wait_drain();
    repeat (2) @(negedge clk);
    check("t1_stable", {31'd0, key_stable}, 1);
    check("t1_att", {28'd0, attempt_cnt}, 1);

    // zero commit does not count as an attempt
    set_key(8'h00, 4'd1, 1'b1);
    wait_drain();

    // glitch during settling restarts the window
    set_key(8'hB6, 4'd0, 1'b0);
    repeat (2) @(negedge clk);
    raw_key = 8'hB7;
    repeat (2) @(negedge clk);
    raw_key = 8'hB6;
    sb.push_back('{8'hB6, 4'd2, cyc + 7});
    wait_drain();
    check("t2_key", {24'd0, key_out}, 32'hB6);

    @(negedge clk);
    clear_attempts = 1'b1;
    @(negedge clk);
    clear_attempts = 1'b0;
    check("clr_att", {28'd0, attempt_cnt}, 0);

    set_key(8'h11, 4'd1, 1'b1);
    wait_drain();
    set_key(8'h22, 4'd2, 1'b1);
    wait_drain();
    @(negedge clk);
    clear_attempts = 1'b1;
    @(negedge clk);
    clear_attempts = 1'b0;
    set_key(8'h33, 4'd1, 1'b1);
    wait_drain();
    set_key(8'h44, 4'd2, 1'b1);
    wait_drain();
    repeat (2) @(negedge clk);
    check("t4_att", {28'd0, attempt_cnt}, 2);
    check("t4_thr", {31'd0, throttled}, 0);

    // clear on the commit edge wins over the increment
    set_key(8'h55, 4'd0, 1'b1);
    repeat (6) @(negedge clk);
    clear_attempts = 1'b1;
    @(negedge clk);
    clear_attempts = 1'b0;
    wait_drain();
    check("same_edge_att", {28'd0, attempt_cnt}, 0);

    // three attempts trip backoff
    set_key(8'h11, 4'd1, 1'b1);
    wait_drain();
    set_key(8'h22, 4'd2, 1'b1);
    wait_drain();
    set_key(8'h33, 4'd3, 1'b1);
    t_bo = sb[$].cyc;
    wait_drain();
    bo_tick();
    check("bo_thr", {31'd0, throttled}, 1);
    check("bo_key", {24'd0, key_out}, 0);
    raw_key = 8'h77;
    clear_attempts = 1'b1;
    repeat (200) bo_tick();
    clear_attempts = 1'b0;
    ena = 1'b0;
    repeat (100) bo_tick();
    ena = 1'b1;
    sb.push_back('{8'h77, 4'd1, t_bo + 1025});
    while (cyc < t_bo + 1023) bo_tick();
    check("bo_blank", bo_bad, 0);
    check("bo_thr_end", {31'd0, throttled}, 1);
    @(negedge clk);
    check("bo_exit_thr", {31'd0, throttled}, 0);
    check("bo_exit_att", {28'd0, attempt_cnt}, 0);
    check("bo_exit_key", {24'd0, key_out}, 0);
    wait_drain();

    // second backoff, then async reset mid-window
    set_key(8'h12, 4'd2, 1'b1);
    wait_drain();
    set_key(8'h34, 4'd3, 1'b1);
    wait_drain();
    set_key(8'hB6, 4'd0, 1'b0);
    repeat (20) @(negedge clk);
    check("t6_thr", {31'd0, throttled}, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_key", {24'd0, key_out}, 0);
    check("t6_rst_thr", {31'd0, throttled}, 0);
    check("t6_rst_att", {28'd0, attempt_cnt}, 0);
    check("t6_rst_stable", {31'd0, key_stable}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{8'hB6, 4'd1, cyc + 7});
    wait_drain();
    repeat (2) @(negedge clk);
    check("t6_key", {24'd0, key_out}, 32'hB6);
    check("t6_thr_end", {31'd0, throttled}, 0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
